// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between the fetch (IF) and load/store (DM) ports.
// One transaction in flight at a time; DM has fixed priority, but after
// STARVE_LIMIT consecutive DM grants taken while IF waited, IF is forced through.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_ack,
  output logic                    if_rvalid,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  input  logic                    dm_req,
  input  logic                    dm_we,
  input  logic [ADDR_WIDTH-1:0]   dm_addr,
  input  logic [DATA_WIDTH-1:0]   dm_wdata,
  input  logic [DATA_WIDTH/8-1:0] dm_wstrb,
  output logic                    dm_ack,
  output logic                    dm_rvalid,
  output logic [DATA_WIDTH-1:0]   dm_rdata,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    busy
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_t;

  state_t         state, state_nxt;
  owner_t         owner, owner_nxt;
  owner_t         sel;         // requester currently driving the memory port
  logic           grant;       // memory accepted the request this cycle
  logic [CW-1:0]  starve, starve_nxt;

  // State, owner and starvation counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      owner  <= OWN_NONE;
      starve <= '0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      starve <= starve_nxt;
    end
  end

  // Arbitration, next state, handshakes and response routing
  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    sel        = OWN_NONE;
    grant      = 1'b0;
    if_rvalid  = 1'b0;
    dm_rvalid  = 1'b0;
    if_rdata   = '0;
    dm_rdata   = '0;
    starve_nxt = starve;
    case (state)
      S_IDLE: begin
        if (dm_req && !(if_req && starve == LIMIT)) sel = OWN_DM;
        else if (if_req)                            sel = OWN_IF;
        if (sel != OWN_NONE) begin
          owner_nxt = sel;
          grant     = mem_gnt;
          state_nxt = mem_gnt ? S_RESP : S_ADDR;
        end
      end
      S_ADDR: begin
        sel = owner;
        if (mem_gnt) begin
          grant     = 1'b1;
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (mem_rvalid) begin
          if (owner == OWN_IF) begin
            if_rvalid = 1'b1;
            if_rdata  = mem_rdata;
          end else if (owner == OWN_DM) begin
            dm_rvalid = 1'b1;
            dm_rdata  = mem_rdata;
          end
          state_nxt = S_IDLE;
          owner_nxt = OWN_NONE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        owner_nxt = OWN_NONE;
      end
    endcase
    mem_req = (sel != OWN_NONE);
    if_ack  = grant && (sel == OWN_IF);
    dm_ack  = grant && (sel == OWN_DM);
    if (grant) begin
      if (sel == OWN_DM && if_req) starve_nxt = (starve == LIMIT) ? starve : starve + 1'b1;
      else                         starve_nxt = '0;
    end
  end

  // Memory payload mux from the requester currently driving the port
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (sel == OWN_IF) begin
      mem_addr = if_addr;
    end else if (sel == OWN_DM) begin
      mem_we    = dm_we;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
      mem_wstrb = dm_wstrb;
    end
  end

  assign busy = (state != S_IDLE);

endmodule
